sc_frame_decoder: RTL and testbench

SC_FRAME_DECODER -- requirements
Module: sc_frame_decoder

---
 rtl/sc_frame_decoder.sv | 90 +++++++++
 tb/tb_sc_frame_decoder.sv | 119 +++++++++++
 2 files changed

// File: rtl/sc_frame_decoder.sv
// sc_frame_decoder: converts a binary operand into a stochastic bitstream against
// Sobol samples and counts the ones over each FRAME_LEN-sample frame.
module sc_frame_decoder #(
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_in,
    input  logic [5:0] x,
    input  logic [5:0] rnd,
    input  logic       rnd_valid,
    output logic       sc_bit,
    output logic       sc_bit_valid,
    output logic [5:0] ones,
    output logic       done,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [5:0] LAST = 6'(FRAME_LEN);

    state_t     state_q, state_d;
    logic [5:0] x_q, x_d, cnt_q, cnt_d, acc_q, acc_d, ones_q, ones_d;
    logic       sc_bit_q, sc_bit_d, sc_bit_valid_q, sc_bit_valid_d;
    logic       accept, cmp_bit;

    always_comb begin
        accept         = en_in & rnd_valid;
        // A frame's first sample compares against the live operand, later ones against the latched copy
        cmp_bit        = (state_q == ACCUM) ? (rnd < x_q) : (rnd < x);
        state_d        = state_q;
        x_d            = x_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        ones_d         = ones_q;
        sc_bit_valid_d = accept;
        sc_bit_d       = accept ? cmp_bit : sc_bit_q;
        if (!en_in) begin
            state_d  = IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            sc_bit_d = 1'b0;
        end else if (accept) begin
            if (state_q == ACCUM) begin
                if (cnt_q + 6'd1 == LAST) begin
                    ones_d  = acc_q + {5'd0, cmp_bit};
                    state_d = DONE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    acc_d = acc_q + {5'd0, cmp_bit};
                end
            end else begin
                x_d     = x;
                cnt_d   = 6'd1;
                acc_d   = {5'd0, cmp_bit};
                state_d = ACCUM;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            x_q            <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            ones_q         <= '0;
            sc_bit_q       <= 1'b0;
            sc_bit_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            ones_q         <= ones_d;
            sc_bit_q       <= sc_bit_d;
            sc_bit_valid_q <= sc_bit_valid_d;
        end
    end

    assign sc_bit       = sc_bit_q;
    assign sc_bit_valid = sc_bit_valid_q;
    assign ones         = ones_q;
    assign done         = (state_q == DONE);
    assign busy         = (state_q == ACCUM);
endmodule

// File: tb/tb_sc_frame_decoder.sv
// tb_sc_frame_decoder: directed vectors with hand-computed frame counts for sc_frame_decoder.
module tb_sc_frame_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_in = 1'b0;
    logic [5:0] x = '0;
    logic [5:0] rnd = '0;
    logic       rnd_valid = 1'b0;
    logic       sc_bit, sc_bit_valid, done, busy;
    logic [5:0] ones;
    int         n_checks = 0;
    int         n_fail = 0;

    sc_frame_decoder #(.FRAME_LEN(16)) dut (
        .clk(clk), .rst(rst), .en_in(en_in), .x(x), .rnd(rnd), .rnd_valid(rnd_valid),
        .sc_bit(sc_bit), .sc_bit_valid(sc_bit_valid), .ones(ones), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n samples rnd=0,4,8,...; x switches to xnew from sample chg onward.
    task automatic run_frame(input logic [5:0] xv, input int n, input int gap, input int chg,
                             input logic [5:0] xnew, input logic [5:0] exp_ones);
        for (int i = 0; i < n; i++) begin
            x         = (i >= chg) ? xnew : xv;
            rnd       = 6'(4 * i);
            rnd_valid = 1'b1;
            tick();
            rnd_valid = 1'b0;
            check($sformatf("valid[%0d]", i), sc_bit_valid, 1);
            check($sformatf("bit[%0d]", i), sc_bit, (4 * i) < xv);
            if (i == 15) begin
                check("done_last", done, 1);
                check("ones", ones, exp_ones);
                check("busy_last", busy, 0);
            end else begin
                check($sformatf("done[%0d]", i), done, 0);
                check($sformatf("busy[%0d]", i), busy, 1);
            end
            if (i != n - 1)
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("gap_valid", sc_bit_valid, 0);
                    check("gap_busy", busy, 1);
                end
        end
    endtask

    task automatic idle_check(input logic [5:0] exp_ones);
        tick();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", sc_bit_valid, 0);
        check("idle_ones", ones, exp_ones);
    endtask

    initial begin
        #12;
        check("rst_bit", sc_bit, 0);
        check("rst_valid", sc_bit_valid, 0);
        check("rst_ones", ones, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        en_in = 1'b1;
        tick();
        run_frame(6'd32, 16, 0, 99, 6'd0, 6'd8);
        idle_check(6'd8);
        run_frame(6'd0, 16, 0, 99, 6'd0, 6'd0);
        idle_check(6'd0);
        run_frame(6'd63, 16, 0, 99, 6'd0, 6'd16);
        idle_check(6'd16);
        run_frame(6'd32, 16, 1, 3, 6'd0, 6'd8);
        idle_check(6'd8);
        run_frame(6'd16, 16, 0, 99, 6'd0, 6'd4);
        run_frame(6'd48, 16, 0, 99, 6'd0, 6'd12);
        idle_check(6'd12);
        run_frame(6'd63, 7, 0, 99, 6'd0, 6'd0);
        en_in = 1'b0;
        tick();
        check("en_busy", busy, 0);
        check("en_bit", sc_bit, 0);
        check("en_valid", sc_bit_valid, 0);
        check("en_done", done, 0);
        check("en_ones", ones, 12);
        tick();
        en_in = 1'b1;
        run_frame(6'd32, 16, 0, 99, 6'd0, 6'd8);
        idle_check(6'd8);
        run_frame(6'd63, 5, 0, 99, 6'd0, 6'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_bit", sc_bit, 0);
        check("arst_valid", sc_bit_valid, 0);
        check("arst_ones", ones, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        tick();
        #2 rst = 1'b1;
        tick();
        run_frame(6'd16, 16, 0, 99, 6'd0, 6'd4);
        idle_check(6'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
